axi_lite_led_slave: RTL
=======================

Name: axi_lite_led_slave

Overview:
- AXI4-Lite slave (responder) that owns the LED register file at BASE_ADDR and drives the board LED pins.
- Sits behind the JTAG-to-AXI bridge master inside the top level and answers its single-beat reads and writes.
- Provides a static LED data register, a hardware blink generator and a read-only ID register.
- Unmapped or unaligned accesses get an error response and cause no side effects.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
BASE_ADDR, 32'h43C00000, base of the 16-byte register window
NUM_LEDS, 4, LED count (1..16)
ID_VALUE, 32'h1ED0_0001, value returned by the ID register

Ports:
sys_clk  in  1  clock
sys_resetn  in  1  reset, asynchronous, active-low
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
led_pins  out  NUM_LEDS  LED drive, registered

Behaviour:
Register map (offset = addr - BASE_ADDR):
- 0x00 LED_DATA, RW, [NUM_LEDS-1:0]; all other bits read 0.
- 0x04 unmapped.
- 0x08 BLINK_CTRL, RW; [NUM_LEDS-1:0] mask, [31:16] period in clocks.
- 0x0C ID, RO; returns ID_VALUE. Writes return SLVERR and have no effect.
- Any other address, addr[1:0]!=0, or a write to ID: resp=2'b10 (SLVERR), no state change, rdata=0. OKAY=2'b00.

Reset (async assert, sync release):
- awready=wready=arready=1.
- bvalid=rvalid=0, bresp=rresp=0, rdata=0.
- LED_DATA=0, BLINK_CTRL=0, blink counter=0, phase=0, led_pins=0.

Write FSM, states W_IDLE and W_RESP:
- W_IDLE: awready stays high until an AW handshake is captured, then drops. wready behaves the same way for the W handshake. AW and W may arrive in either order or in the same cycle.
- Once both are captured (at the clock edge of the later handshake), the write commits, the FSM enters W_RESP and bvalid rises. The register update and bvalid are on the same edge.
- W_RESP: bvalid and bresp are held until bready is sampled high. Then return to W_IDLE with awready=wready=1 on the next cycle.
- Only one write is outstanding at a time; no AW/W acceptance while in W_RESP.
- wstrb: each byte lane updates only if its strobe is 1. An all-zero strobe to a valid register returns OKAY with no change.
- Writing BLINK_CTRL with any strobe set clears the blink counter and phase to 0.

Read FSM, states R_IDLE and R_DATA:
- R_IDLE: arready=1. On handshake, capture rdata/rresp from the current register values, drop arready and set rvalid on the next edge.
- R_DATA: rdata, rresp and rvalid are held stable until rready is high, then return to R_IDLE.
- Read and write channels are independent and may be active simultaneously. An AR handshake on the same edge as a write commit returns the pre-write value.

Blink:
- period==0: counter and phase held at 0.
- Otherwise the counter increments each clock. When counter>=period-1 it wraps to 0 and phase toggles, giving a half-period of `period` clocks.
- led_pins <= LED_DATA ^ (mask & {NUM_LEDS{phase}}), registered. led_pins reflects a committed write one clock after the commit edge.

Reset mid-transaction: FSMs return to IDLE and any pending response is dropped.

Test Plan:
- Reset, then write 0x0000000A to BASE+0x00 with wstrb=4'hF → bresp=OKAY; led_pins=4'b1010 one clock after bvalid; read BASE+0x00 → rdata=0x0000000A, rresp=OKAY.
- Write 0xDEADBEEF to BASE+0x04 → bresp=SLVERR, led_pins unchanged. Read BASE+0x04 and BASE+0x02 → rresp=SLVERR, rdata=0. Read BASE+0x0C → 0x1ED00001.
- W beat presented 3 cycles before AW, then AW and W in the same cycle; bready held low 5 cycles → no second acceptance while bvalid=1; bvalid held stable; a single commit per transaction.
- LED_DATA=0x0, BLINK_CTRL=0x0004_0003 → led_pins[1:0] toggle 00/11 every 4 clocks, led_pins[3:2]=00. Write BLINK_CTRL=0 → led_pins returns to 0000 and stays there.
- Write LED_DATA=0xF with wstrb=0 → OKAY, no change. Concurrent read of 0x00 with AR handshake on the commit edge of a write of 0x5 (from 0x3) → rdata=0x3; a subsequent read → 0x5.
- Assert sys_resetn low during W_RESP with bvalid high → bvalid=0 and all registers 0 immediately; after release, awready=wready=arready=1.

Source files
------------

// File: rtl/axi_lite_led_slave.sv
// AXI4-Lite register slave for the board LEDs: static LED data, hardware blinker, read-only ID.
// Single outstanding write and read; unmapped, unaligned or read-only writes answer SLVERR.
module axi_lite_led_slave #(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = AXI_ADDR_WIDTH'(32'h43C0_0000),
  parameter int unsigned                NUM_LEDS       = 4,
  parameter logic [31:0]                ID_VALUE       = 32'h1ED0_0001
) (
  input  logic                          sys_clk,
  input  logic                          sys_resetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [NUM_LEDS-1:0]           led_pins
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned PERIOD_W = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_LED   = 2'd0;
  localparam logic [1:0] REG_BLINK = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // {mapped, word index}; mapped excludes the hole at 0x04 and unaligned offsets
  function automatic logic [2:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    logic                      hit;
    off = addr - BASE_ADDR;
    hit = (off[AXI_ADDR_WIDTH-1:4] == '0) && (off[1:0] == 2'b00) && (off[3:2] != 2'd1);
    return {hit, off[3:2]};
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [AXI_DATA_WIDTH-1:0] cur,
    input logic [AXI_DATA_WIDTH-1:0] data,
    input logic [STRB_W-1:0]         strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    end
    return res;
  endfunction

  logic [0:0]                w_state, w_state_nxt;
  logic                      aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_nxt;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [STRB_W-1:0]         wstrb_q, wstrb_nxt;
  logic                      awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]                bresp_nxt;

  logic [0:0]                r_state, r_state_nxt;
  logic                      arready_nxt, rvalid_nxt;
  logic [1:0]                rresp_nxt;
  logic [AXI_DATA_WIDTH-1:0] rdata_nxt;

  logic [NUM_LEDS-1:0]       led_data, led_data_nxt;
  logic [NUM_LEDS-1:0]       blink_mask, blink_mask_nxt;
  logic [PERIOD_W-1:0]       blink_period, blink_period_nxt;
  logic [PERIOD_W-1:0]       blink_cnt, blink_cnt_nxt;
  logic                      blink_phase, blink_phase_nxt;

  logic                      aw_hs_c, w_hs_c, ar_hs_c, wr_commit_c, wr_ok_c, blink_clr_c;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_c;
  logic [AXI_DATA_WIDTH-1:0] wr_data_c, rd_val_c, led_word_c, blink_word_c;
  logic [STRB_W-1:0]         wr_strb_c;
  logic [2:0]                wr_sel_c, rd_sel_c;

  assign aw_hs_c = s_axi_awvalid & s_axi_awready;
  assign w_hs_c  = s_axi_wvalid & s_axi_wready;
  assign ar_hs_c = s_axi_arvalid & s_axi_arready;

  // A handshake on the commit edge bypasses the capture registers
  assign wr_addr_c = aw_hs_c ? s_axi_awaddr : awaddr_q;
  assign wr_data_c = w_hs_c ? s_axi_wdata : wdata_q;
  assign wr_strb_c = w_hs_c ? s_axi_wstrb : wstrb_q;
  assign wr_sel_c  = decode(wr_addr_c);
  assign wr_ok_c   = wr_sel_c[2] && (wr_sel_c[1:0] != REG_ID);
  assign rd_sel_c  = decode(s_axi_araddr);

  assign led_word_c   = AXI_DATA_WIDTH'(led_data);
  assign blink_word_c = AXI_DATA_WIDTH'({blink_period, PERIOD_W'(blink_mask)});
  assign blink_clr_c  = wr_commit_c && wr_ok_c && (wr_sel_c[1:0] == REG_BLINK) && (|wr_strb_c);

  // Write channel FSM
  always_comb begin
    w_state_nxt = w_state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    awaddr_nxt  = awaddr_q;
    wdata_nxt   = wdata_q;
    wstrb_nxt   = wstrb_q;
    awready_nxt = s_axi_awready;
    wready_nxt  = s_axi_wready;
    bvalid_nxt  = s_axi_bvalid;
    bresp_nxt   = s_axi_bresp;
    wr_commit_c = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs_c) begin
          aw_done_nxt = 1'b1;
          awaddr_nxt  = s_axi_awaddr;
          awready_nxt = 1'b0;
        end
        if (w_hs_c) begin
          w_done_nxt = 1'b1;
          wdata_nxt  = s_axi_wdata;
          wstrb_nxt  = s_axi_wstrb;
          wready_nxt = 1'b0;
        end
        if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) begin
          wr_commit_c = 1'b1;
          w_state_nxt = W_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          bvalid_nxt  = 1'b1;
          bresp_nxt   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_nxt = W_IDLE;
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          wready_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_val_c = '0;
    case (rd_sel_c[1:0])
      REG_LED:   rd_val_c = led_word_c;
      REG_BLINK: rd_val_c = blink_word_c;
      REG_ID:    rd_val_c = AXI_DATA_WIDTH'(ID_VALUE);
      default:   rd_val_c = '0;
    endcase
  end

  // Read channel FSM; captures register values present before any same-edge write
  always_comb begin
    r_state_nxt = r_state;
    arready_nxt = s_axi_arready;
    rvalid_nxt  = s_axi_rvalid;
    rresp_nxt   = s_axi_rresp;
    rdata_nxt   = s_axi_rdata;
    case (r_state)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_state_nxt = R_DATA;
          arready_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          rresp_nxt   = rd_sel_c[2] ? RESP_OKAY : RESP_SLVERR;
          rdata_nxt   = rd_sel_c[2] ? rd_val_c : '0;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_nxt = R_IDLE;
          arready_nxt = 1'b1;
          rvalid_nxt  = 1'b0;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    led_data_nxt     = led_data;
    blink_mask_nxt   = blink_mask;
    blink_period_nxt = blink_period;
    if (wr_commit_c && wr_ok_c) begin
      if (wr_sel_c[1:0] == REG_LED) begin
        led_data_nxt = NUM_LEDS'(merge_bytes(led_word_c, wr_data_c, wr_strb_c));
      end else begin
        blink_mask_nxt   = NUM_LEDS'(merge_bytes(blink_word_c, wr_data_c, wr_strb_c));
        blink_period_nxt = PERIOD_W'(merge_bytes(blink_word_c, wr_data_c, wr_strb_c) >> PERIOD_W);
      end
    end
  end

  // Blink generator: phase flips every `period` clocks
  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if (blink_clr_c || (blink_period == '0)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b0;
    end else if (blink_cnt >= PERIOD_W'(blink_period - PERIOD_W'(1))) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end else begin
      blink_cnt_nxt = PERIOD_W'(blink_cnt + PERIOD_W'(1));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      w_state       <= W_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      led_data      <= '0;
      blink_mask    <= '0;
      blink_period  <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      led_pins      <= '0;
    end else begin
      w_state       <= w_state_nxt;
      aw_done       <= aw_done_nxt;
      w_done        <= w_done_nxt;
      awaddr_q      <= awaddr_nxt;
      wdata_q       <= wdata_nxt;
      wstrb_q       <= wstrb_nxt;
      s_axi_awready <= awready_nxt;
      s_axi_wready  <= wready_nxt;
      s_axi_bvalid  <= bvalid_nxt;
      s_axi_bresp   <= bresp_nxt;
      r_state       <= r_state_nxt;
      s_axi_arready <= arready_nxt;
      s_axi_rvalid  <= rvalid_nxt;
      s_axi_rresp   <= rresp_nxt;
      s_axi_rdata   <= rdata_nxt;
      led_data      <= led_data_nxt;
      blink_mask    <= blink_mask_nxt;
      blink_period  <= blink_period_nxt;
      blink_cnt     <= blink_cnt_nxt;
      blink_phase   <= blink_phase_nxt;
      led_pins      <= led_data ^ (blink_mask & {NUM_LEDS{blink_phase}});
    end
  end

endmodule
